// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, counter widths and the baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Counts ticks within one bit; wide enough for oversample ratios up to 256.
    localparam int TICK_CTR_W = 8;
    // Indexes payload bits; covers frames of up to 8 data bits.
    localparam int BIT_IDX_W  = 3;

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int bps, input int ovs);
        return (clk_hz + (bps * ovs) / 2) / (bps * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running modulo-DIV counter with a synchronous
// restart so the tick phase can be realigned to a detected start edge.
module uart_baud_tick #(
    parameter int DIV = 430
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Count 0..DIV-1, wrapping on the last value or jumping to 0 on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises rx, qualifies the start bit, samples each bit
// at its centre, assembles the payload and hands it downstream over valid/ready.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 66_000_000,
    parameter int BITRATE_BPS = 9_600,
    parameter int OVS         = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_ovr,
    output logic [7:0]           frame_cnt
);

    localparam int DIV = calc_div(CLK_HZ, BITRATE_BPS, OVS);
    localparam logic [TICK_CTR_W-1:0] HALF_LAST = TICK_CTR_W'(OVS / 2 - 1);
    localparam logic [TICK_CTR_W-1:0] FULL_LAST = TICK_CTR_W'(OVS - 1);
    localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    logic                  sync1_reg, sync2_reg, rx_prev_reg;
    logic                  rx_s;
    logic                  tick;
    logic                  start_edge;

    rx_state_e             state_reg;
    logic [TICK_CTR_W-1:0] tick_ctr_reg;
    logic [BIT_IDX_W-1:0]  bit_idx_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  wait_high_reg;
    logic                  done_reg;
    logic                  fe_pend_reg;

    logic [DATA_BITS-1:0]  rx_data_reg;
    logic                  rx_valid_reg;
    logic                  frame_err_reg;
    logic                  overrun_reg;
    logic [7:0]            frame_cnt_reg;

    // Two-flop synchroniser plus one history flop for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync1_reg   <= rx;
            sync2_reg   <= sync1_reg;
            rx_prev_reg <= sync2_reg;
        end
    end

    assign rx_s = sync2_reg;

    // A start edge is honoured only in IDLE, and not while waiting for the line to recover
    // after a frame whose stop bit was sampled low.
    assign start_edge = (state_reg == IDLE) && !wait_high_reg && rx_prev_reg && !rx_s;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_edge),
        .tick    (tick)
    );

    // Receive FSM: start qualification at half a bit, then one sample per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tick_ctr_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            wait_high_reg <= 1'b0;
            done_reg      <= 1'b0;
            fe_pend_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wait_high_reg && rx_s) begin
                        wait_high_reg <= 1'b0;
                    end
                    if (start_edge) begin
                        state_reg    <= START;
                        tick_ctr_reg <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_ctr_reg == HALF_LAST) begin
                            tick_ctr_reg <= '0;
                            if (!rx_s) begin
                                state_reg   <= DATA;
                                bit_idx_reg <= '0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            tick_ctr_reg <= tick_ctr_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_ctr_reg == FULL_LAST) begin
                            tick_ctr_reg           <= '0;
                            shift_reg[bit_idx_reg] <= rx_s;
                            if (bit_idx_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= PARITY;
`else
                                state_reg <= STOP;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                            end
                        end else begin
                            tick_ctr_reg <= tick_ctr_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tick_ctr_reg == FULL_LAST) begin
                            tick_ctr_reg <= '0;
                            state_reg    <= STOP;
                        end else begin
                            tick_ctr_reg <= tick_ctr_reg + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (tick_ctr_reg == FULL_LAST) begin
                            tick_ctr_reg  <= '0;
                            fe_pend_reg   <= ~rx_s;
                            wait_high_reg <= ~rx_s;
                            done_reg      <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            tick_ctr_reg <= tick_ctr_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pe_pend_reg;
    logic parity_err_reg;

    // Parity error = received parity bit differs from XOR of payload (inverted for odd parity).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_pend_reg <= 1'b0;
        end else if (state_reg == PARITY && tick && tick_ctr_reg == FULL_LAST) begin
            pe_pend_reg <= rx_s ^ (^shift_reg) ^ PARITY_ODD[0];
        end
    end

    // Parity status travels with the payload it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
        end else if (done_reg && (!rx_valid_reg || rx_ready)) begin
            parity_err_reg <= pe_pend_reg;
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    // Delivery: load a finished frame if the slot is free or being emptied this cycle,
    // otherwise drop it and flag overrun; count every finished frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
            if (done_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg   <= shift_reg;
                    frame_err_reg <= fe_pend_reg;
                    rx_valid_reg  <= 1'b1;
                end else begin
                    // Placed after the clear so a simultaneous set wins.
                    overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed testbench for uart_rx_sequencer at 1.6 MHz / 10 kbps / OVS 16 (160 clk per bit).
module tb_uart_rx_sequencer;
    import uart_pkg::*;

    localparam int BIT_CLKS = 160;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b1;
    logic       clr_ovr  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [7:0] frame_cnt;

    int         checks  = 0;
    int         errors  = 0;
    int         vcnt    = 0;
    int         exp_cnt = 0;
    logic       got     = 1'b0;
    logic [7:0] cap_d   = '0;
    logic       cap_fe  = 1'b0;
    logic       cap_pe  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_sequencer #(
        .CLK_HZ      (1_600_000),
        .BITRATE_BPS (10_000),
        .OVS         (16),
        .DATA_BITS   (8),
        .PARITY_ODD  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr),
        .frame_cnt  (frame_cnt)
    );

    // Drive rx at a level for n clocks, recording rx_valid cycles and the first delivered word.
    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                if (!got) begin
                    got    = 1'b1;
                    cap_d  = rx_data;
                    cap_fe = frame_err;
                    cap_pe = parity_err;
                end
                vcnt++;
            end
        end
    endtask

    // Send one complete frame; optional extra low time after the stop bit, then 40 idle clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int tail_low);
        got  = 1'b0;
        vcnt = 0;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold(par, BIT_CLKS);
`else
        if (par === 1'bx) hold(1'b1, 0);
`endif
        hold(stop, BIT_CLKS);
        if (tail_low > 0) hold(1'b0, tail_low);
        hold(1'b1, 40);
        exp_cnt = (exp_cnt + 1) % 256;
        $display("frame 0x%02h stop=%0d par=%0d: valid_cycles=%0d data=0x%02h fe=%0d pe=%0d cnt=%0d ovr=%0d",
                 d, stop, par, vcnt, cap_d, cap_fe, cap_pe, frame_cnt, overrun);
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got 0x%02h expected 0x00", rx_data); end
        checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got fe=%0b pe=%0b ovr=%0b expected 0/0/0", frame_err, parity_err, overrun);
        end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("reset: valid=%0b data=0x%02h cnt=%0d", rx_valid, rx_data, frame_cnt);
    endtask

    task automatic test_glitch();
        got  = 1'b0;
        vcnt = 0;
        hold(1'b0, 50);
        hold(1'b1, 300);
        $display("glitch: valid_cycles=%0d cnt=%0d state=%0d", vcnt, frame_cnt, dut.state_reg);
        checks++; if (vcnt != 0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", vcnt); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL glitch_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected IDLE", dut.state_reg); end
    endtask

    task automatic test_basic();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        checks++; if (vcnt != 1) begin errors++; $display("FAIL basic_valid_len: got %0d expected 1", vcnt); end
        checks++; if (cap_d !== 8'hA5) begin errors++; $display("FAIL basic_data: got 0x%02h expected 0xA5", cap_d); end
        checks++; if (cap_fe !== 1'b0) begin errors++; $display("FAIL basic_fe: got %0b expected 0", cap_fe); end
        checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL basic_pe: got %0b expected 0", cap_pe); end
        checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL basic_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_frame_err();
        // 0x3C ends with two zero bits, so the line stays low through the stop bit and 300 clk beyond.
        send_frame(8'h3C, 1'b0, 1'b0, 300);
        checks++; if (vcnt != 1) begin errors++; $display("FAIL ferr_valid_len: got %0d expected 1", vcnt); end
        checks++; if (cap_d !== 8'h3C) begin errors++; $display("FAIL ferr_data: got 0x%02h expected 0x3C", cap_d); end
        checks++; if (cap_fe !== 1'b1) begin errors++; $display("FAIL ferr_fe: got %0b expected 1", cap_fe); end
        checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL ferr_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_overrun();
        do_reset();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_first: got valid=%0b data=0x%02h expected 1/0x11", rx_valid, rx_data);
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %0b expected 0", overrun); end
        send_frame(8'h22, 1'b1, 1'b0, 0);
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_keep: got 0x%02h expected 0x11", rx_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL ovr_cnt: got %0d expected 2", frame_cnt); end
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        @(negedge clk);
        $display("clr_ovr: ovr=%0b valid=%0b data=0x%02h", overrun, rx_valid, rx_data);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %0b expected 0", overrun); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_hold: got valid=%0b data=0x%02h expected 1/0x11", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        $display("accept: valid=%0b", rx_valid);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got valid=%0b expected 0", rx_valid); end
        rx_ready = 1'b1;
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0);
        checks++; if (cap_pe !== 1'b1) begin errors++; $display("FAIL par_bad: got pe=%0b expected 1", cap_pe); end
        checks++; if (cap_d !== 8'h07) begin errors++; $display("FAIL par_bad_data: got 0x%02h expected 0x07", cap_d); end
        send_frame(8'h07, 1'b1, 1'b1, 0);
        checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL par_good: got pe=%0b expected 0", cap_pe); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL par_good_len: got %0d expected 1", vcnt); end
`else
        send_frame(8'h07, 1'b1, 1'b0, 0);
        checks++; if (cap_pe !== 1'b0) begin errors++; $display("FAIL par_off: got pe=%0b expected 0", cap_pe); end
        checks++; if (cap_d !== 8'h07) begin errors++; $display("FAIL par_off_data: got 0x%02h expected 0x07", cap_d); end
`endif
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, 0);
        checks++; if (cap_d !== 8'h81 || vcnt != 1) begin
            errors++; $display("FAIL b2b_first: got 0x%02h len %0d expected 0x81 len 1", cap_d, vcnt);
        end
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        checks++; if (cap_d !== 8'h7E || vcnt != 1) begin
            errors++; $display("FAIL b2b_second: got 0x%02h len %0d expected 0x7E len 1", cap_d, vcnt);
        end
        checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d    = 8'h5A;
        got  = 1'b0;
        vcnt = 0;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(d[i], BIT_CLKS);
        hold(d[4], 80);
        rst_n = 1'b0;
        #1;
        $display("mid-frame reset: valid=%0b data=0x%02h cnt=%0d", rx_valid, rx_data, frame_cnt);
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_out: got valid=%0b data=0x%02h expected 0/0x00", rx_valid, rx_data);
        end
        checks++; if (frame_cnt !== 8'd0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_cnt: got cnt=%0d fe=%0b expected 0/0", frame_cnt, frame_err);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        hold(1'b1, 200);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        checks++; if (cap_d !== 8'h5A || vcnt != 1) begin
            errors++; $display("FAIL rstmid_next: got 0x%02h len %0d expected 0x5A len 1", cap_d, vcnt);
        end
        checks++; if (frame_cnt !== 8'd1 || cap_fe !== 1'b0) begin
            errors++; $display("FAIL rstmid_next_cnt: got cnt=%0d fe=%0b expected 1/0", frame_cnt, cap_fe);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_basic();
        test_frame_err();
        test_overrun();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
